// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_DATA} arb_state_t;

  typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;

  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles while enabled, cleared on grant, saturating.
// expired is high in the cycle whose closing edge brings the count to TIMEOUT.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = en && (cnt_q >= (CntMax - 1'b1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory bus between fetch and load/store ports, with a hang watchdog.
// Optional one-entry fetch buffer enabled by defining MEM_ARBITER_FETCH_BUF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  output logic              cpu_stall,
  output logic              err
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              wr_q, wr_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic              d_req, f_req, gnt_data, gnt_fetch;
  logic              busy_state, done, abort, wd_clr, wd_expired;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_rdata;

  assign d_req = (d_ren | d_wen) & ~d_ack_q;
  assign f_req = if_req & ~if_ack_q;
  // Fetch wins a tie only right after a data grant, so fetch cannot starve.
  assign gnt_data  = d_req & ~(f_req & (last_grant_q == GNT_DATA));
  assign gnt_fetch = f_req & ~gnt_data;

  assign busy_state = (state_q != ARB_IDLE);
  assign done       = busy_state & ~bus_busy;
  assign abort      = busy_state & bus_busy & wd_expired;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (wd_clr),
    .en     (busy_state),
    .expired(wd_expired)
  );

`ifdef MEM_ARBITER_FETCH_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;

  assign buf_hit   = buf_valid_q && (if_addr == buf_addr_q);
  assign buf_rdata = buf_data_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (abort) begin
      buf_valid_q <= 1'b0;
    end else if (done && (state_q == ARB_FETCH)) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= addr_q;
      buf_data_q  <= bus_rdata;
    end else if (done && (state_q == ARB_DATA) && wr_q &&
                 (addr_q[ADDR_W-1:2] == buf_addr_q[ADDR_W-1:2])) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    wd_clr       = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_data) begin
          state_d = ARB_DATA;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          sel_d   = d_sel;
          wr_d    = d_wen;
          wd_clr  = 1'b1;
        end else if (gnt_fetch) begin
          if (buf_hit) begin
            if_ack_d     = 1'b1;
            if_rdata_d   = buf_rdata;
            last_grant_d = GNT_FETCH;
          end else begin
            state_d = ARB_FETCH;
            addr_d  = if_addr;
            sel_d   = SEL_ALL;
            wr_d    = 1'b0;
            wd_clr  = 1'b1;
          end
        end
      end
      ARB_FETCH: begin
        if (done || abort) begin
          state_d      = ARB_IDLE;
          if_ack_d     = 1'b1;
          if_rdata_d   = done ? bus_rdata : '0;
          last_grant_d = GNT_FETCH;
          if (abort) err_d = 1'b1;
        end
      end
      ARB_DATA: begin
        if (done || abort) begin
          state_d      = ARB_IDLE;
          d_ack_d      = 1'b1;
          d_rdata_d    = (done && !wr_q) ? bus_rdata : '0;
          last_grant_d = GNT_DATA;
          if (abort) err_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      wr_q         <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  // Strobes derive from state so they drop the same edge the FSM returns to idle or resets.
  assign bus_ren   = (state_q == ARB_FETCH) | ((state_q == ARB_DATA) & ~wr_q);
  assign bus_wen   = (state_q == ARB_DATA) & wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign cpu_stall = (if_req & ~if_ack_q) | ((d_ren | d_wen) & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4); covers the fetch buffer when
// MEM_ARBITER_FETCH_BUF_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_FETCH_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_ren, d_wen;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel;
  logic        d_ack;
  logic        bus_ren, bus_wen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_busy;
  logic        cpu_stall;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_ren    (d_ren),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_sel    (d_sel),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .bus_ren  (bus_ren),
    .bus_wen  (bus_wen),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_sel  (bus_sel),
    .bus_rdata(bus_rdata),
    .bus_busy (bus_busy),
    .cpu_stall(cpu_stall),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; if_req = 1'b0; if_addr = '0;
    d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
    bus_rdata = '0; bus_busy = 1'b0;
    step(); step();
    check_eq("rst_ren", {31'b0, bus_ren}, 0);
    check_eq("rst_wen", {31'b0, bus_wen}, 0);
    check_eq("rst_addr", bus_addr, 0);
    check_eq("rst_sel", {28'b0, bus_sel}, 0);
    check_eq("rst_acks", {30'b0, if_ack, d_ack}, 0);
    check_eq("rst_err", {31'b0, err}, 0);
    nrst = 1'b1;
    step();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h10; bus_rdata = 32'h3e800093;
    #1 check_eq("f_stall_req", {31'b0, cpu_stall}, 1);
    step();
    check_eq("f_ren", {31'b0, bus_ren}, 1);
    check_eq("f_addr", bus_addr, 32'h10);
    check_eq("f_sel", {28'b0, bus_sel}, 32'hf);
    check_eq("f_noack", {31'b0, if_ack}, 0);
    check_eq("f_stall", {31'b0, cpu_stall}, 1);
    step();
    check_eq("f_ack", {31'b0, if_ack}, 1);
    check_eq("f_rdata", if_rdata, 32'h3e800093);
    check_eq("f_ren_off", {31'b0, bus_ren}, 0);
    check_eq("f_stall_off", {31'b0, cpu_stall}, 0);
    if_req = 1'b0;
    step();
    check_eq("f_ack_pulse", {31'b0, if_ack}, 0);

    // Simultaneous requests: data first, then fetch
    if_req = 1'b1; if_addr = 32'h14; d_ren = 1'b1; d_addr = 32'h100; bus_rdata = 32'h11111111;
    step();
    check_eq("s_d_addr", bus_addr, 32'h100);
    check_eq("s_d_ren", {31'b0, bus_ren}, 1);
    step();
    check_eq("s_d_ack", {31'b0, d_ack}, 1);
    check_eq("s_d_rdata", d_rdata, 32'h11111111);
    check_eq("s_gap", {30'b0, bus_ren, bus_wen}, 0);
    check_eq("s_f_wait", {31'b0, if_ack}, 0);
    d_ren = 1'b0; bus_rdata = 32'h22222222;
    step();
    check_eq("s_f_addr", bus_addr, 32'h14);
    check_eq("s_f_ren", {31'b0, bus_ren}, 1);
    step();
    check_eq("s_f_ack", {31'b0, if_ack}, 1);
    check_eq("s_f_rdata", if_rdata, 32'h22222222);
    if_req = 1'b0;
    step();

    // Store with both strobes and a 3-cycle busy memory
    d_wen = 1'b1; d_ren = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_sel = 4'b0011;
    bus_busy = 1'b1; bus_rdata = 32'h55555555;
    step();
    d_addr = 32'h99; d_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check_eq("st_wen", {31'b0, bus_wen}, 1);
      check_eq("st_ren", {31'b0, bus_ren}, 0);
      check_eq("st_addr", bus_addr, 32'h20);
      check_eq("st_noack", {31'b0, d_ack}, 0);
      step();
    end
    bus_busy = 1'b0;
    check_eq("st_wen4", {31'b0, bus_wen}, 1);
    check_eq("st_wdata", bus_wdata, 32'hDEADBEEF);
    check_eq("st_sel", {28'b0, bus_sel}, 32'h3);
    step();
    check_eq("st_ack", {31'b0, d_ack}, 1);
    check_eq("st_rdata", d_rdata, 0);
    check_eq("st_wen_off", {31'b0, bus_wen}, 0);
    check_eq("st_noerr", {31'b0, err}, 0);
    d_wen = 1'b0; d_ren = 1'b0;
    step();

    // Timeout with memory stuck busy
    d_ren = 1'b1; d_addr = 32'h30; bus_busy = 1'b1; bus_rdata = 32'h77777777;
    step();
    check_eq("to_addr", bus_addr, 32'h30);
    step(); step(); step();
    check_eq("to_ren4", {31'b0, bus_ren}, 1);
    check_eq("to_noack4", {31'b0, d_ack}, 0);
    check_eq("to_noerr4", {31'b0, err}, 0);
    step();
    check_eq("to_ack", {31'b0, d_ack}, 1);
    check_eq("to_rdata", d_rdata, 0);
    check_eq("to_err", {31'b0, err}, 1);
    check_eq("to_ren_off", {31'b0, bus_ren}, 0);
    d_ren = 1'b0; bus_busy = 1'b0;
    step(); step();
    check_eq("to_err_sticky", {31'b0, err}, 1);

    // Reset during a fetch
    if_req = 1'b1; if_addr = 32'h50; bus_busy = 1'b1;
    step();
    check_eq("r_ren", {31'b0, bus_ren}, 1);
    nrst = 1'b0;
    step();
    check_eq("r_ren_off", {31'b0, bus_ren}, 0);
    check_eq("r_noack", {31'b0, if_ack}, 0);
    check_eq("r_err", {31'b0, err}, 0);
    check_eq("r_addr", bus_addr, 0);
    nrst = 1'b1; if_req = 1'b0; bus_busy = 1'b0;
    step();
    check_eq("r_noack2", {31'b0, if_ack}, 0);
    check_eq("r_idle", {30'b0, bus_ren, bus_wen}, 0);

    // Fetch buffer: repeat fetch, invalidating store, fetch again
    if_req = 1'b1; if_addr = 32'h40; bus_rdata = 32'hAAAA0001;
    step();
    check_eq("b_ren1", {31'b0, bus_ren}, 1);
    step();
    check_eq("b_rdata1", if_rdata, 32'hAAAA0001);
    if_req = 1'b0;
    step();
    if_req = 1'b1; bus_rdata = 32'hBBBB0002;
    step();
    if (BufEn) begin
      check_eq("b_hit_noren", {31'b0, bus_ren}, 0);
      check_eq("b_hit_ack", {31'b0, if_ack}, 1);
      check_eq("b_hit_rdata", if_rdata, 32'hAAAA0001);
    end else begin
      check_eq("b_ren2", {31'b0, bus_ren}, 1);
      step();
      check_eq("b_rdata2", if_rdata, 32'hBBBB0002);
    end
    if_req = 1'b0;
    step();
    d_wen = 1'b1; d_addr = 32'h42; d_wdata = 32'h1; d_sel = 4'b1111;
    step();
    check_eq("b_st_wen", {31'b0, bus_wen}, 1);
    step();
    check_eq("b_st_ack", {31'b0, d_ack}, 1);
    d_wen = 1'b0;
    step();
    if_req = 1'b1;
    step();
    check_eq("b_ren3", {31'b0, bus_ren}, 1);
    check_eq("b_addr3", bus_addr, 32'h40);
    step();
    check_eq("b_ack3", {31'b0, if_ack}, 1);
    check_eq("b_rdata3", if_rdata, 32'hBBBB0002);
    if_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
